// File: rtl/riscv_dmem.sv
// Empty package; the controller is riscv_dmem_ctrl in riscv_dmem_ctrl.sv.
package riscv_dmem_unused_pkg;
endpackage

// File: rtl/riscv_state_pkg.sv
// Shared types and helpers for the data-memory controller.
//   dmem_state_e  : controller FSM states
//   dmem_size_e   : access size encodings carried on size_i
//   is_misaligned : 1 when an access of the given size at the given byte
//                   offset would cross a word boundary
package riscv_state_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2,
    ST_DONE  = 2'd3
  } dmem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } dmem_size_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (dmem_size_e'(size))
      SZ_HALF: mis = (off == 2'd3);
      SZ_WORD: mis = (off != 2'd0);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/riscv_dmem_lane.sv
// Byte-lane steering between the right-aligned core side and the
// lane-aligned bus side.
// Ports:
//   off_i    byte offset inside the word (adr[1:0])
//   size_i   access size (byte/half/word)
//   beat2_i  1 selects the lanes that spill into the following word
//   d_i      right-aligned store data
//   be_o     byte enables for the current beat
//   bus_d_o  lane-aligned store data for the current beat
//   q_lo_i   read data of the lower word (first beat)
//   q_hi_i   read data of the upper word (second beat, don't-care if none)
//   q_o      right-aligned, zero-extended load data
// Both words are treated as one 2*XLEN window so the same shift serves
// single-beat and split accesses.
module riscv_dmem_lane
  import riscv_state_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              beat2_i,
  input  logic [XLEN-1:0]   d_i,
  output logic [XLEN/8-1:0] be_o,
  output logic [XLEN-1:0]   bus_d_o,
  input  logic [XLEN-1:0]   q_lo_i,
  input  logic [XLEN-1:0]   q_hi_i,
  output logic [XLEN-1:0]   q_o
);

  localparam int BW = XLEN / 8;

  logic [BW-1:0]     size_be;
  logic [XLEN-1:0]   size_mask;
  logic [2*BW-1:0]   be_wide;
  logic [2*XLEN-1:0] d_wide;
  logic [2*XLEN-1:0] q_wide;

  always_comb begin
    size_be   = '0;
    size_mask = '0;
    case (dmem_size_e'(size_i))
      SZ_BYTE: begin
        size_be   = BW'(1);
        size_mask = XLEN'(8'hFF);
      end
      SZ_HALF: begin
        size_be   = BW'(3);
        size_mask = XLEN'(16'hFFFF);
      end
      SZ_WORD: begin
        size_be   = '1;
        size_mask = '1;
      end
      default: begin
        size_be   = '0;
        size_mask = '0;
      end
    endcase
  end

  assign be_wide = {{BW{1'b0}}, size_be} << off_i;
  assign d_wide  = {{XLEN{1'b0}}, d_i & size_mask} << {off_i, 3'b000};

  assign be_o    = beat2_i ? be_wide[2*BW-1:BW]     : be_wide[BW-1:0];
  assign bus_d_o = beat2_i ? d_wide[2*XLEN-1:XLEN]  : d_wide[XLEN-1:0];

  assign q_wide = {q_hi_i, q_lo_i} >> {off_i, 3'b000};
  assign q_o    = q_wide[XLEN-1:0] & size_mask;

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller for the memory stage: accepts one load/store,
// runs one (or two, when splitting) bus beats, and reports completion,
// bus error/timeout or misalignment with a one-cycle pulse.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_i/we_i/size_i/adr_i/d_i       core request (right-aligned data)
//   flush_i                           kill the current instruction
//   stall_o/done_o/q_o                pipeline stall, completion, load data
//   misaligned_o/err_o                exception pulses (replace done_o)
//   bus_req_o/bus_we_o/bus_adr_o/
//   bus_be_o/bus_d_o                  bus beat (all zero while idle)
//   bus_ack_i/bus_err_i/bus_q_i       bus beat response
// Build option: RV_DMEM_MISALIGNED_SPLIT_EN splits word-crossing accesses
// into two beats; without it they raise misaligned_o with no bus traffic.
//
// state    | meaning
// ST_IDLE  | waiting for a request; accepts it combinationally
// ST_BEAT1 | first (or only) bus beat outstanding
// ST_BEAT2 | second beat of a split access (next word)
// ST_DONE  | one-cycle result pulse: done_o, err_o or misaligned_o
module riscv_dmem_ctrl
  import riscv_state_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic [XLEN-1:0]   adr_i,
  input  logic [XLEN-1:0]   d_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [XLEN-1:0]   q_o,
  output logic              misaligned_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [XLEN-1:0]   bus_adr_o,
  output logic [XLEN/8-1:0] bus_be_o,
  output logic [XLEN-1:0]   bus_d_o,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [XLEN-1:0]   bus_q_i
);

  localparam int BW = XLEN / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  // Down-counter reload: terminal count 0 is reached after TIMEOUT beat cycles.
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);

  dmem_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] adr_q, adr_d;
  logic [XLEN-1:0] d_q, d_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] q1_q, q1_d;
  logic [1:0]      size_q, size_d;
  logic            we_q, we_d;
  logic            split_q, split_d;
  logic            flush_q, flush_d;
  logic            err_q, err_d;
  logic            mis_q, mis_d;

  logic            beat2;
  logic            bus_req;
  logic            flush_seen;
  logic            mis_req;
  logic [BW-1:0]   lane_be;
  logic [XLEN-1:0] lane_d;
  logic [XLEN-1:0] lane_q;
  logic [XLEN-1:0] q_lo;

  assign beat2   = (state_q == ST_BEAT2);
  assign mis_req = is_misaligned(size_i, adr_i[1:0]);
  // A split load keeps the first word until the second beat arrives.
  assign q_lo    = split_q ? q1_q : bus_q_i;

  riscv_dmem_lane #(.XLEN(XLEN)) u_lane (
    .off_i   (adr_q[1:0]),
    .size_i  (size_q),
    .beat2_i (beat2),
    .d_i     (d_q),
    .be_o    (lane_be),
    .bus_d_o (lane_d),
    .q_lo_i  (q_lo),
    .q_hi_i  (bus_q_i),
    .q_o     (lane_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      d_q     <= '0;
      q_q     <= '0;
      q1_q    <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      split_q <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      d_q     <= d_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      size_q  <= size_d;
      we_q    <= we_d;
      split_q <= split_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    adr_d        = adr_q;
    d_d          = d_q;
    q_d          = q_q;
    q1_d         = q1_q;
    size_d       = size_q;
    we_d         = we_q;
    split_d      = split_q;
    flush_d      = flush_q;
    err_d        = err_q;
    mis_d        = mis_q;
    flush_seen   = 1'b0;
    stall_o      = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    misaligned_o = 1'b0;
    bus_req      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_i && !flush_i) begin
          stall_o = 1'b1;
          adr_d   = adr_i;
          d_d     = d_i;
          size_d  = size_i;
          we_d    = we_i;
          split_d = 1'b0;
          flush_d = 1'b0;
          err_d   = 1'b0;
          mis_d   = 1'b0;
          cnt_d   = CNT_LOAD;
          if (size_i == SZ_ILL) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (mis_req) begin
`ifdef RV_DMEM_MISALIGNED_SPLIT_EN
            split_d = 1'b1;
            state_d = ST_BEAT1;
`else
            mis_d   = 1'b1;
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_BEAT1;
          end
        end
      end

      ST_BEAT1, ST_BEAT2: begin
        stall_o    = 1'b1;
        bus_req    = 1'b1;
        // A flush never cuts a beat short; it only suppresses what follows.
        flush_seen = flush_q | flush_i;
        flush_d    = flush_seen;
        if (bus_err_i || (!bus_ack_i && cnt_q == '0)) begin
          err_d   = !flush_seen;
          state_d = flush_seen ? ST_IDLE : ST_DONE;
        end else if (bus_ack_i) begin
          if (flush_seen) begin
            state_d = ST_IDLE;
          end else if (state_q == ST_BEAT1 && split_q) begin
            q1_d    = bus_q_i;
            cnt_d   = CNT_LOAD;
            state_d = ST_BEAT2;
          end else begin
            if (!we_q) q_d = lane_q;
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DONE: begin
        done_o       = !err_q && !mis_q;
        err_o        = err_q;
        misaligned_o = mis_q;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Reset quiets every handshake output in the same cycle, mid-beat included.
    if (rst_i) begin
      stall_o      = 1'b0;
      done_o       = 1'b0;
      err_o        = 1'b0;
      misaligned_o = 1'b0;
      bus_req      = 1'b0;
    end
  end

  assign q_o       = q_q;
  assign bus_req_o = bus_req;
  assign bus_we_o  = bus_req & we_q;
  assign bus_adr_o = bus_req ? ({adr_q[XLEN-1:2], 2'b00} + (beat2 ? XLEN'(4) : XLEN'(0))) : '0;
  assign bus_be_o  = bus_req ? lane_be : '0;
  assign bus_d_o   = bus_req ? lane_d : '0;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
module tb_riscv_dmem_ctrl;

`ifdef RV_DMEM_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'd0;
  logic [31:0] adr_i = '0;
  logic [31:0] d_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, done_o, misaligned_o, err_o;
  logic [31:0] q_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_adr_o, bus_d_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_i = 1'b0;
  logic [31:0] bus_q_i = '0;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_adr [2];
  logic [3:0]  exp_be  [2];
  logic [31:0] exp_dat [2];
  logic [31:0] exp_qv;
  logic        exp_ill, exp_mis;
  int          exp_nbeats;

  riscv_dmem_ctrl #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .adr_i(adr_i), .d_i(d_i), .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o),
    .q_o(q_o), .misaligned_o(misaligned_o), .err_o(err_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o), .bus_be_o(bus_be_o), .bus_d_o(bus_d_o),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_q_i(bus_q_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-by-byte model: each accessed byte lands in word (off+i)/4, lane (off+i)%4.
  task automatic predict(input logic [1:0] size, input logic [31:0] adr,
                         input logic [31:0] d, input logic [31:0] r1, input logic [31:0] r2);
    int nb, off, bi, ln;
    logic [31:0] rw;
    nb = 1 << size;
    off = int'(adr % 4);
    exp_ill = (size == 2'd3);
    exp_mis = !exp_ill && (off + nb > 4);
    exp_adr[0] = adr & ~32'd3;
    exp_adr[1] = exp_adr[0] + 32'd4;
    exp_be[0] = '0; exp_be[1] = '0;
    exp_dat[0] = '0; exp_dat[1] = '0;
    exp_qv = '0;
    if (!exp_ill) begin
      for (int i = 0; i < nb; i++) begin
        bi = (off + i) / 4;
        ln = (off + i) % 4;
        exp_be[bi][ln] = 1'b1;
        exp_dat[bi][8*ln +: 8] = d[8*i +: 8];
        rw = (bi == 0) ? r1 : r2;
        exp_qv[8*i +: 8] = rw[8*ln +: 8];
      end
    end
    exp_nbeats = exp_ill ? 0 : (exp_mis ? (SPLIT ? 2 : 0) : 1);
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Runs one access from acceptance to the idle cycle after the result.
  // resp: 0 ack, 1 bus_err, 2 ack and err together.
  task automatic run_access(input logic we, input logic [1:0] size, input logic [31:0] adr,
                            input logic [31:0] d, input logic [31:0] r1, input logic [31:0] r2,
                            input int w1, input int w2, input int e1, input int e2);
    int waits [2];
    int resp [2];
    logic [31:0] rd [2];
    logic errd;
    waits[0] = w1; waits[1] = w2;
    resp[0] = e1;  resp[1] = e2;
    rd[0] = r1;    rd[1] = r2;
    predict(size, adr, d, r1, r2);
    req_i = 1'b1; we_i = we; size_i = size; adr_i = adr; d_i = d; flush_i = 1'b0;
    #1 check_eq("stall_accept", 32'(stall_o), 32'd1);
    @(negedge clk_i);
    req_i = 1'b0;
    adr_i = $urandom; d_i = $urandom; size_i = 2'($urandom);
    if (exp_nbeats == 0) begin
      #1;
      check_eq("ill_err", 32'(err_o), 32'(exp_ill));
      check_eq("misaligned", 32'(misaligned_o), 32'(exp_mis));
      check_eq("exc_done", 32'(done_o), 32'd0);
      check_eq("exc_busreq", 32'(bus_req_o), 32'd0);
      check_eq("exc_stall", 32'(stall_o), 32'd0);
      @(negedge clk_i);
      #1 check_eq("exc_pulse_end", {30'd0, err_o, misaligned_o}, 32'd0);
      check_eq("exc_busreq2", 32'(bus_req_o), 32'd0);
      return;
    end
    errd = 1'b0;
    for (int b = 0; b < exp_nbeats; b++) begin
      for (int w = 0; w <= waits[b]; w++) begin
        if (w == waits[b]) begin
          bus_ack_i = (resp[b] != 1);
          bus_err_i = (resp[b] != 0);
          bus_q_i = rd[b];
        end else begin
          bus_q_i = $urandom;
        end
        #1;
        check_eq("beat_req", {30'd0, bus_req_o, stall_o}, 32'd3);
        check_eq("beat_adr", bus_adr_o, exp_adr[b]);
        check_eq("beat_be", 32'(bus_be_o), 32'(exp_be[b]));
        check_eq("beat_we", 32'(bus_we_o), 32'(we));
        if (we) check_eq("beat_data", bus_d_o & be_mask(bus_be_o), exp_dat[b]);
        check_eq("beat_no_pulse", {29'd0, done_o, err_o, misaligned_o}, 32'd0);
        @(negedge clk_i);
        bus_ack_i = 1'b0; bus_err_i = 1'b0;
      end
      if (resp[b] != 0) begin
        errd = 1'b1;
        break;
      end
    end
    #1;
    check_eq("res_done", 32'(done_o), 32'(!errd));
    check_eq("res_err", 32'(err_o), 32'(errd));
    check_eq("res_mis", 32'(misaligned_o), 32'd0);
    check_eq("res_stall", {30'd0, stall_o, bus_req_o}, 32'd0);
    if (!we && !errd) check_eq("load_q", q_o, exp_qv);
    @(negedge clk_i);
    #1;
    check_eq("idle_pulses", {29'd0, done_o, err_o, misaligned_o}, 32'd0);
    check_eq("idle_busreq", 32'(bus_req_o), 32'd0);
    if (!we && !errd) check_eq("load_q_hold", q_o, exp_qv);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {27'd0, stall_o, done_o, err_o, misaligned_o, bus_req_o}, 32'd0);
    check_eq({tag, "_q"}, q_o, 32'd0);
    check_eq({tag, "_bus"}, bus_adr_o | 32'(bus_be_o) | bus_d_o, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1 check_all_zero("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Word load, two wait cycles: done in the 4th cycle after the request.
    run_access(1'b0, 2'd2, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 2, 0, 0, 0);
    // Byte store to the top lane.
    run_access(1'b1, 2'd0, 32'h103, 32'h5A, 32'h0, 32'h0, 0, 0, 0, 0);
    // Word load crossing into the next word.
    run_access(1'b0, 2'd2, 32'h102, 32'h0, 32'hAABBCCDD, 32'h11223344, 1, 0, 0, 0);
    // Half load at offset 3, illegal size, and ack+err together.
    run_access(1'b0, 2'd1, 32'h203, 32'h0, 32'h89ABCDEF, 32'h01234567, 0, 1, 0, 0);
    run_access(1'b1, 2'd3, 32'h200, 32'h1234, 32'h0, 32'h0, 0, 0, 0, 0);
    run_access(1'b0, 2'd1, 32'h202, 32'h0, 32'hCAFEF00D, 32'h0, 1, 0, 2, 0);

    // Timeout: no response at all.
    req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; adr_i = 32'h300;
    @(negedge clk_i);
    req_i = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!bus_req_o) break;
      n++;
      @(negedge clk_i);
    end
    check_eq("to_req_cycles", n, 32'd4);
    check_eq("to_err", {29'd0, err_o, done_o, stall_o}, 32'b100);
    @(negedge clk_i);
    #1 check_eq("to_err_end", 32'(err_o), 32'd0);

    // Flush while the (first) beat is outstanding.
    a = SPLIT ? 32'h402 : 32'h400;
    req_i = 1'b1; we_i = 1'b1; size_i = 2'd2; adr_i = a; d_i = 32'h55667788;
    @(negedge clk_i);
    req_i = 1'b0; flush_i = 1'b1;
    #1 check_eq("flush_req_kept", 32'(bus_req_o), 32'd1);
    @(negedge clk_i);
    flush_i = 1'b0; bus_ack_i = 1'b1;
    #1 check_eq("flush_req_kept2", 32'(bus_req_o), 32'd1);
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    #1 check_eq("flush_after", {27'd0, stall_o, done_o, err_o, misaligned_o, bus_req_o}, 32'd0);
    @(negedge clk_i);
    #1 check_eq("flush_no_beat2", {30'd0, bus_req_o, done_o}, 32'd0);

    // Reset in the last outstanding beat, then a late ack.
    req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; adr_i = a;
    @(negedge clk_i);
    req_i = 1'b0;
    if (SPLIT) begin
      bus_ack_i = 1'b1; bus_q_i = 32'h12345678;
      @(negedge clk_i);
      bus_ack_i = 1'b0;
    end
    #1 check_eq("rst_in_beat", 32'(bus_req_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 check_all_zero("rst_mid");
    bus_ack_i = 1'b1;
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    #1 check_all_zero("late_ack");

    // Random accesses with interleaved flushed (ignored) requests.
    for (int t = 0; t < 60; t++) begin
      logic [1:0] sz;
      int e1, e2;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      e1 = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      e2 = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      run_access(1'($urandom), sz, 32'h1000 + ($urandom_range(0, 63) * 4) + $urandom_range(0, 3),
                 $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), e1, e2);
      if ($urandom_range(0, 3) == 0) begin
        req_i = 1'b1; flush_i = 1'b1; size_i = 2'd2; adr_i = 32'h500;
        #1 check_eq("flush_idle_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        req_i = 1'b0; flush_i = 1'b0;
        #1 check_eq("flush_idle_bus", {30'd0, bus_req_o, stall_o}, 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_ctrl.md
RISCV_DMEM_CTRL -- requirements
Module: riscv_dmem_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum bus-wait cycles per beat before a bus error.
REQ-003 SHALL have ports:
- clk_i  in  1  clock; all logic rising-edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  1  memory-stage load/store valid (non-bubble).
- we_i  in  1  1=store, 0=load.
- size_i  in  2  0=byte, 1=half, 2=word; 3 illegal.
- adr_i  in  XLEN  byte address.
- d_i  in  XLEN  store data, right-aligned.
- flush_i  in  1  kill the current instruction (upstream exception).
- stall_o  out  1  pipeline stall request.
- done_o  out  1  access complete pulse.
- q_o  out  XLEN  load data, right-aligned, zero-extended.
- misaligned_o  out  1  misaligned exception pulse.
- err_o  out  1  bus error/timeout pulse.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write.
- bus_adr_o  out  XLEN  word-aligned address, [1:0]=0.
- bus_be_o  out  XLEN/8  byte enables.
- bus_d_o  out  XLEN  lane-aligned write data.
- bus_ack_i  in  1  beat complete.
- bus_err_i  in  1  beat error.
- bus_q_i  in  XLEN  lane-aligned read data.

Function
REQ-004 SHALL implement FSM states IDLE, BEAT1, BEAT2, DONE.
REQ-005 In IDLE, req_i=1 with flush_i=0 SHALL be accepted: stall_o=1 combinationally that cycle; next state BEAT1, or DONE with misaligned_o=1 if misaligned (REQ-012); size_i=3 -> DONE with err_o=1, no bus beat.
REQ-006 In BEAT1/BEAT2, bus_req_o=1 with bus_adr_o/bus_we_o/bus_be_o/bus_d_o stable until bus_ack_i or bus_err_i is sampled high; the beat ends on that edge.
REQ-007 bus_ack_i and bus_err_i high together SHALL be treated as error.
REQ-008 stall_o SHALL be 1 in IDLE-accept, BEAT1 and BEAT2; 0 in DONE and idle.
REQ-009 DONE SHALL last exactly one cycle with done_o=1 and stall_o=0, then return to IDLE; q_o is valid and held from DONE until the next access is accepted.
REQ-010 Latency: request in cycle T, bus_req_o high from T+1; ack in cycle T+k -> done_o in T+k+1.
REQ-011 A per-beat wait counter SHALL reset at beat start; reaching TIMEOUT without ack -> bus_req_o drops, err_o=1 in DONE.
REQ-012 Misaligned means a half access with adr[1:0]=3 or a word access with adr[1:0]!=0 (crossing a word boundary).
REQ-013 bus_be_o/bus_d_o SHALL shift byte lanes by adr[1:0]; a load extracts lanes back to q_o[ size-1:0 ], upper bits zero.
REQ-014 bus_err_i or timeout in BEAT1 SHALL skip BEAT2; err_o, misaligned_o and done_o are mutually exclusive per access, and exception pulses replace done_o.
REQ-015 flush_i during BEAT1/BEAT2 SHALL NOT drop a pending bus_req_o; the beat completes, BEAT2 is not issued, and the FSM returns to IDLE with no done_o/err_o pulse.
REQ-016 flush_i in DONE SHALL have no effect.

Reset
REQ-017 rst_i SHALL force IDLE, counter 0, bus_req_o=0, stall_o=0, done_o=0, misaligned_o=0, err_o=0, q_o=0, even mid-beat.
REQ-018 A beat interrupted by reset SHALL be abandoned; a late bus_ack_i in IDLE is ignored.

Configuration
REQ-019 Macro RV_DMEM_MISALIGNED_SPLIT_EN defined: misaligned accesses SHALL be split into BEAT1 (adr word, upper lanes) and BEAT2 (adr+4, remaining lanes), merging load data into q_o, with no misaligned_o.
REQ-020 Macro undefined: misaligned accesses SHALL raise misaligned_o in DONE with no bus activity; BEAT2 unreachable.

Structure
REQ-021 State enum, size encodings (BYTE/HALF/WORD) and the misalignment function SHALL reside in riscv_state_pkg.
REQ-022 Lane steering (be/data shift and load extract) SHALL be one sub-module riscv_dmem_lane.

Verification
REQ-023 Load word adr=0x100, ack after 2 waits, bus_q_i=0xDEADBEEF -> bus_be_o=4'hF, done_o at T+4, q_o=0xDEADBEEF.
REQ-024 Store byte adr=0x103, d_i=0x5A -> bus_be_o=4'h8, bus_d_o[31:24]=0x5A, single beat.
REQ-025 Load word adr=0x102: split build -> beats 0x100 (be 4'hC) and 0x104 (be 4'h3), q_o={q2[15:0],q1[31:16]}; non-split build -> misaligned_o=1 at T+1, bus_req_o never high.
REQ-026 Load, no ack, TIMEOUT=4 -> bus_req_o high 4 cycles, then err_o=1 for one cycle, stall_o=0.
REQ-027 Split store with flush_i in BEAT1 -> BEAT1 completes on ack, no BEAT2, no done_o; rst_i in BEAT2 -> IDLE next cycle, all outputs 0.
